// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared defaults and FSM state type for the factorial dispatcher
package factorial_pkg;
   localparam int W_DEFAULT       = 10;
   localparam int DEPTH_DEFAULT   = 4;
   localparam int TIMEOUT_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/factorial_req_fifo.sv
// rtl/factorial_req_fifo.sv - in-order operand queue feeding the dispatcher
module factorial_req_fifo
   import factorial_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CW'(1);
         end
      end
   end
endmodule

// File: rtl/factorial_dispatch.sv
// rtl/factorial_dispatch.sv - queues factorial requests and runs one core job at a time with timeout
module factorial_dispatch
   import factorial_pkg::*;
#(
   parameter int W       = W_DEFAULT,
   parameter int DEPTH   = DEPTH_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] req_n,
   input  logic         req_valid,
   output logic         req_ready,
   output logic [W-1:0] core_n,
   output logic         core_go,
   input  logic [W-1:0] core_result,
   input  logic         core_result_valid,
   output logic [W-1:0] rsp_n,
   output logic [W-1:0] rsp_result,
   output logic         rsp_err,
   output logic         rsp_valid,
   input  logic         rsp_ready
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state;
   state_t        next_state;
   logic [W-1:0]  cur_n;
   logic [W-1:0]  result_q;
   logic          err_q;
   logic [TW-1:0] timer;
   logic          timed_out;

   logic          push;
   logic          pop;
   logic [W-1:0]  fifo_head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   factorial_req_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (req_n),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign req_ready  = (fifo_count < CW'(DEPTH)) && !rst;
   assign push       = req_valid && req_ready && !fifo_full;
   assign timed_out  = (timer == TW'(TIMEOUT - 1));
   assign core_n     = cur_n;
   assign rsp_n      = cur_n;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      core_go    = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            core_go    = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            if (core_result_valid || timed_out) begin
               next_state = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_n    <= '0;
         timer    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (pop) begin
                  cur_n <= fifo_head;
               end
            end
            ISSUE: timer <= '0;
            WAIT: begin
               timer <= timer + TW'(1);
               // a result arriving on the last allowed cycle still wins over the timeout
               if (core_result_valid) begin
                  result_q <= core_result;
                  err_q    <= 1'b0;
               end else if (timed_out) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_factorial_dispatch.sv
// tb/tb_factorial_dispatch.sv - self-checking bench for factorial_dispatch with a behavioural core model
module tb_factorial_dispatch;
   import factorial_pkg::*;

   localparam int W       = 10;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int NJOBS   = 40;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] req_n;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] core_n;
   logic         core_go;
   logic [W-1:0] core_result;
   logic         core_result_valid;
   logic [W-1:0] rsp_n;
   logic [W-1:0] rsp_result;
   logic         rsp_err;
   logic         rsp_valid;
   logic         rsp_ready;

   typedef struct {
      int n;
      int res;
      bit err;
   } job_t;

   job_t exp_q[$];
   int   delay_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   stale_cnt = 0;
   int   stale_done = 0;

   factorial_dispatch #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_n             (req_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .core_n            (core_n),
      .core_go           (core_go),
      .core_result       (core_result),
      .core_result_valid (core_result_valid),
      .rsp_n             (rsp_n),
      .rsp_result        (rsp_result),
      .rsp_err           (rsp_err),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready)
   );

   always #5 clk = ~clk;

   function automatic int fact_mod(input int n);
      longint r = 1;
      for (int i = 2; i <= n; i++) r = (r * i) % (longint'(1) << W);
      return int'(r);
   endfunction

   // Core model: result arrives in WAIT cycle index d; d >= TIMEOUT means the core stays silent
   int  core_cnt = 0;
   int  core_cur = 0;
   bit  core_busy = 1'b0;
   bit  core_silent = 1'b0;
   initial begin
      core_result_valid = 1'b0;
      core_result       = '0;
   end
   always @(negedge clk) begin
      core_result_valid = 1'b0;
      if (rst) begin
         core_busy = 1'b0;
      end else if (stale_cnt != stale_done) begin
         core_result_valid = 1'b1;
         core_result       = W'(333);
         stale_done++;
      end else if (core_busy) begin
         if (core_cnt == 0) begin
            if (!core_silent) begin
               core_result_valid = 1'b1;
               core_result       = W'(fact_mod(core_cur));
            end
            core_busy = 1'b0;
         end else begin
            core_cnt--;
         end
      end
      if (core_go && !rst) begin
         core_cur    = int'(core_n);
         core_cnt    = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
         core_silent = (core_cnt >= TIMEOUT);
         core_busy   = 1'b1;
      end
   end

   task automatic send(input int n, input int d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         req_n     = W'(n);
         req_valid = 1'b1;
         if (req_ready) begin
            delay_q.push_back(d);
            ok = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [W-1:0] n, output logic [W-1:0] r, output logic e, output bit ok);
      ok = 1'b0;
      n = '0; r = '0; e = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (rsp_valid) begin
            n = rsp_n; r = rsp_result; e = rsp_err; ok = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            return;
         end
         @(negedge clk);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      logic [4*W+3:0] outs;
      rst = 1'b1; req_valid = 1'b0; req_n = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      outs = {req_ready, core_go, core_n, rsp_valid, rsp_n, rsp_result, rsp_err};
      n_checks++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_reset: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_single;
      logic [2:0] go_trace;
      logic [W-1:0] go_n, n, r; logic e; bit ok; int lat;
      req_valid = 1'b1; req_n = W'(4); delay_q.push_back(10);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_accept: req_ready %b expected 1", req_ready);
      end
      go_n = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         go_trace[i] = core_go;
         if (i == 1) go_n = core_n;
      end
      n_checks++;
      if (go_trace !== 3'b010 || go_n !== W'(4)) begin
         n_fail++; $display("FAIL single_go_timing: trace %b core_n %0d expected 010 and 4", go_trace, go_n);
      end
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(negedge clk); lat++;
      end
      n_checks++;
      if (lat !== 12) begin
         n_fail++; $display("FAIL single_rsp_latency: %0d cycles after go, expected 12", lat);
      end
      wait_rsp(n, r, e, ok);
      n_checks++;
      if (!ok || n !== W'(4) || r !== W'(24) || e !== 1'b0) begin
         n_fail++; $display("FAIL single_rsp: ok %b n %0d res %0d err %b expected 4/24/0", ok, n, r, e);
      end
   endtask

   task automatic test_wrap;
      logic [W-1:0] n, r; logic e; bit ok, sent;
      send(10, 5, sent);
      wait_rsp(n, r, e, ok);
      n_checks++;
      if (!sent || !ok || n !== W'(10) || r !== W'(768) || e !== 1'b0) begin
         n_fail++; $display("FAIL wrap_rsp: ok %b n %0d res %0d err %b expected 10/768/0", ok, n, r, e);
      end
   endtask

   task automatic test_fifo_full;
      logic [4:0] acc;
      logic [W-1:0] n, r; logic e; bit ok, sent;
      int order[5] = '{6, 1, 2, 3, 4};
      send(6, 40, sent);
      repeat (3) @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         req_valid = 1'b1; req_n = W'(k);
         acc[k-1] = req_ready;
         if (req_ready) delay_q.push_back(2);
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_checks++;
      if (acc !== 5'b01111 || !sent) begin
         n_fail++; $display("FAIL fifo_full_accept: accepted %b expected 01111", acc);
      end
      for (int j = 0; j < 5; j++) begin
         wait_rsp(n, r, e, ok);
         n_checks++;
         if (!ok || n !== W'(order[j]) || r !== W'(fact_mod(order[j])) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_order_%0d: ok %b n %0d res %0d err %b expected %0d/%0d/0",
                     j, ok, n, r, e, order[j], fact_mod(order[j]));
         end
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL fifo_no_extra: rsp_valid %b expected 0", rsp_valid);
      end
   endtask

   task automatic test_timeout;
      logic [W-1:0] n, r; logic e; bit ok, sent; int cyc;
      send(7, 1000, sent);
      for (int i = 0; i < 10 && !core_go; i++) @(negedge clk);
      cyc = 0;
      while (!rsp_valid && cyc < 200) begin
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (!sent || cyc !== TIMEOUT + 1) begin
         n_fail++; $display("FAIL timeout_wait: %0d wait cycles, expected %0d", cyc - 1, TIMEOUT);
      end
      wait_rsp(n, r, e, ok);
      n_checks++;
      if (!ok || n !== W'(7) || r !== W'(0) || e !== 1'b1) begin
         n_fail++; $display("FAIL timeout_rsp: ok %b n %0d res %0d err %b expected 7/0/1", ok, n, r, e);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] n, r, sn, sr; logic e, se; bit ok, s1, s2, unstable, go_seen; int cyc;
      rsp_ready = 1'b0;
      send(2, 3, s1);
      send(5, 3, s2);
      cyc = 0;
      while (!rsp_valid && cyc < 100) begin
         @(negedge clk); cyc++;
      end
      sn = rsp_n; sr = rsp_result; se = rsp_err;
      unstable = 1'b0; go_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_n !== sn || rsp_result !== sr || rsp_err !== se) unstable = 1'b1;
         if (core_go !== 1'b0) go_seen = 1'b1;
      end
      n_checks++;
      if (!s1 || !s2 || unstable || sn !== W'(2) || sr !== W'(2) || se !== 1'b0) begin
         n_fail++; $display("FAIL hold_stable: unstable %b n %0d res %0d err %b expected stable 2/2/0", unstable, sn, sr, se);
      end
      n_checks++;
      if (go_seen) begin
         n_fail++; $display("FAIL hold_no_go: core_go seen %b expected 0", go_seen);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (core_go !== 1'b1 || core_n !== W'(5)) begin
         n_fail++; $display("FAIL next_issue: core_go %b core_n %0d expected 1 and 5", core_go, core_n);
      end
      wait_rsp(n, r, e, ok);
      n_checks++;
      if (!ok || n !== W'(5) || r !== W'(120) || e !== 1'b0) begin
         n_fail++; $display("FAIL next_rsp: ok %b n %0d res %0d err %b expected 5/120/0", ok, n, r, e);
      end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] n, r; logic e; bit ok, s1, s2, s3, leak;
      logic [4*W+3:0] outs;
      send(5, 30, s1);
      send(9, 2, s2);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      outs = {req_ready, core_go, core_n, rsp_valid, rsp_n, rsp_result, rsp_err};
      n_checks++;
      if (!s1 || !s2 || outs !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h expected 0", outs);
      end
      rst = 1'b0;
      delay_q.delete();
      stale_cnt++;
      leak = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || core_go !== 1'b0 || core_n !== '0 || rsp_result !== '0) leak = 1'b1;
      end
      n_checks++;
      if (leak) begin
         n_fail++; $display("FAIL midreset_no_rsp: activity after reset %b expected 0", leak);
      end
      send(3, 4, s3);
      wait_rsp(n, r, e, ok);
      n_checks++;
      if (!s3 || !ok || n !== W'(3) || r !== W'(6) || e !== 1'b0) begin
         n_fail++; $display("FAIL midreset_recover: ok %b n %0d res %0d err %b expected 3/6/0", ok, n, r, e);
      end
   endtask

   task automatic test_random;
      int sent = 0, got = 0, d, nn, sel;
      job_t j;
      exp_q.delete();
      delay_q.delete();
      for (int cyc = 0; cyc < 20000 && got < NJOBS; cyc++) begin
         if (sent < NJOBS && $urandom_range(0, 2) != 0) begin
            req_valid = 1'b1;
            req_n = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, (1 << W) - 1));
         end else begin
            req_valid = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (req_valid && req_ready) begin
            sel = $urandom_range(0, 9);
            d   = (sel == 0) ? TIMEOUT - 1 : (sel == 1) ? TIMEOUT : $urandom_range(0, 15);
            nn  = int'(req_n);
            delay_q.push_back(d);
            j.n = nn;
            j.err = (d >= TIMEOUT);
            j.res = j.err ? 0 : fact_mod(nn);
            exp_q.push_back(j);
            sent++;
         end
         if (rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL random_unexpected: n %0d res %0d err %b with no job pending", rsp_n, rsp_result, rsp_err);
            end else begin
               j = exp_q.pop_front();
               if (rsp_n !== W'(j.n) || rsp_result !== W'(j.res) || rsp_err !== j.err) begin
                  n_fail++;
                  $display("FAIL random_rsp_%0d: n %0d res %0d err %b expected %0d/%0d/%0b",
                           got, rsp_n, rsp_result, rsp_err, j.n, j.res, j.err);
               end
            end
            got++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      n_checks++;
      if (got != NJOBS || exp_q.size() != 0) begin
         n_fail++; $display("FAIL random_complete: got %0d responses expected %0d", got, NJOBS);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_n = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_wrap();
      test_fifo_full();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/factorial_dispatch.md
FACTORIAL_DISPATCH -- requirements
Module: factorial_dispatch

Interface
REQ-001 Parameter W, default 10, data width of n and result.
REQ-002 Parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-003 Parameter TIMEOUT, default 64, maximum WAIT cycles before error response.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_n  in  W  requested factorial operand.
REQ-007 req_valid  in  1  host request valid.
REQ-008 req_ready  out  1  dispatcher can accept request.
REQ-009 core_n  out  W  operand to factorial core.
REQ-010 core_go  out  1  one-cycle start pulse to core.
REQ-011 core_result  in  W  core result.
REQ-012 core_result_valid  in  1  core result valid.
REQ-013 rsp_n  out  W  operand of completed job.
REQ-014 rsp_result  out  W  result of completed job.
REQ-015 rsp_err  out  1  1 = job timed out.
REQ-016 rsp_valid  out  1  response valid.
REQ-017 rsp_ready  in  1  host accepts response.

Function
REQ-018 Request accepted when req_valid && req_ready; req_ready = (count < DEPTH) && !rst, derived from registered count only, no bypass.
REQ-019 FIFO is strict in-order; read/write pointers wrap mod DEPTH; simultaneous push and pop leave count unchanged.
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-021 IDLE: if FIFO non-empty, pop head into cur_n, go to ISSUE; else stay.
REQ-022 ISSUE: core_go=1 for exactly this cycle, core_n=cur_n; clear timer; go to WAIT.
REQ-023 WAIT: core_go=0, core_n held at cur_n; timer increments each cycle.
REQ-024 WAIT with core_result_valid=1: capture core_result, rsp_err=0, go to RESP; result valid takes priority over timeout in the same cycle.
REQ-025 WAIT with timer == TIMEOUT-1 and no result valid: rsp_result=0, rsp_err=1, go to RESP.
REQ-026 RESP: rsp_valid=1, rsp_n=cur_n; all rsp_* stable until rsp_ready=1; on handshake go to IDLE.
REQ-027 core_result_valid outside WAIT is ignored.
REQ-028 Latency: request accepted at edge t gives core_go at cycle t+2 (empty FIFO, FSM idle); result valid in WAIT cycle k gives rsp_valid at k+1.
REQ-029 Result passes through unmodified (core wraps mod 2^W; dispatcher performs no arithmetic on it).
REQ-030 At most one job in flight; no core_go until the prior response handshakes.

Reset
REQ-031 On rst=1 at an edge: FSM to IDLE, FIFO emptied (pointers, count = 0), timer = 0, cur_n = 0.
REQ-032 Output reset values: req_ready 0, core_n 0, core_go 0, rsp_n 0, rsp_result 0, rsp_err 0, rsp_valid 0.
REQ-033 Reset mid-operation discards queued and in-flight jobs; no response is emitted for them.

Structure
REQ-034 Package factorial_pkg holds the W/DEPTH/TIMEOUT defaults and the FSM state enum.
REQ-035 One sub-module, factorial_req_fifo (push/pop, full/empty, count); FSM, timer and response registers live in factorial_dispatch.

Verification
REQ-036 Single request n=4, core model returns 24 after 10 cycles: rsp_n=4, rsp_result=24, rsp_err=0; core_go high exactly 1 cycle, 2 cycles after acceptance.
REQ-037 n=10, core returns 768 (10! mod 1024): rsp_result=768, rsp_err=0.
REQ-038 Job 1 held in WAIT, then push 5 requests (n=1..5): exactly 4 accepted, req_ready=0 on the 5th; after release, responses appear in order n=1,2,3,4.
REQ-039 n=7, core never responds: rsp_valid after 64 WAIT cycles with rsp_n=7, rsp_result=0, rsp_err=1.
REQ-040 rsp_ready=0 for 20 cycles while rsp_valid=1: rsp_* stable, no core_go; rsp_ready=1 completes handshake, next job issues.
REQ-041 rst during WAIT, then a stale core_result_valid: all outputs 0, no response; subsequent n=3 with core result 6 gives rsp_result=6.
